// File: rtl/fifo_pkg.sv
// Shared defaults for the synchronous FIFO slice: data width, depth,
// pointer width and almost-full/almost-empty thresholds.
package fifo_pkg;

  localparam int FIFO_WIDTH     = 16;
  localparam int FIFO_DEPTH     = 8;
  localparam int FIFO_ADR_WIDTH = 3;
  localparam int FIFO_AF_LEVEL  = 6;
  localparam int FIFO_AE_LEVEL  = 2;

endpackage : fifo_pkg

// File: rtl/fifo_mem.sv
// FIFO storage array: one synchronous write port, one combinational read port.
// Contents are deliberately left unreset so the array maps onto plain RAM.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int width     = FIFO_WIDTH,
  parameter int depth     = FIFO_DEPTH,
  parameter int adr_width = FIFO_ADR_WIDTH
) (
  input  logic                 clk_i,
  input  logic                 wrEn_i,
  input  logic [adr_width-1:0] wrAddr_i,
  input  logic [width-1:0]     wrData_i,
  input  logic [adr_width-1:0] rdAddr_i,
  output logic [width-1:0]     rdData_o
);

  logic [width-1:0] memQ [depth];

  always_ff @(posedge clk_i) begin
    if (wrEn_i) begin
      memQ[wrAddr_i] <= wrData_i;
    end
  end

  assign rdData_o = memQ[rdAddr_i];

endmodule : fifo_mem

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read data, occupancy count, status flags
// decoded from the registered count, and one-cycle overflow/underflow pulses.
module sync_fifo
  import fifo_pkg::*;
#(
  parameter int width     = FIFO_WIDTH,
  parameter int depth     = FIFO_DEPTH,
  parameter int adr_width = FIFO_ADR_WIDTH,
  parameter int af_level  = FIFO_AF_LEVEL,
  parameter int ae_level  = FIFO_AE_LEVEL
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic [width-1:0]     data_in,
  input  logic                 we,
  input  logic                 re,
  output logic [width-1:0]     data_out,
  output logic                 data_valid,
  output logic                 fifo_full,
  output logic                 fifo_empty,
  output logic                 almost_full,
  output logic                 almost_empty,
  output logic [adr_width:0]   count,
  output logic                 overflow,
  output logic                 underflow
);

  localparam logic [adr_width:0]   DepthC   = (adr_width + 1)'(depth);
  localparam logic [adr_width:0]   AfC      = (adr_width + 1)'(af_level);
  localparam logic [adr_width:0]   AeC      = (adr_width + 1)'(ae_level);
  localparam logic [adr_width-1:0] LastPtrC = adr_width'(depth - 1);

  logic [adr_width-1:0] wrPtrQ, wrPtrD;
  logic [adr_width-1:0] rdPtrQ, rdPtrD;
  logic [adr_width:0]   countQ, countD;
  logic [width-1:0]     dataOutQ, dataOutD;
  logic [width-1:0]     memRdData;
  logic                 dataValidQ, dataValidD;
  logic                 overflowQ, overflowD;
  logic                 underflowQ, underflowD;
  logic                 rdAccept, wrAccept, memWe;

  assign fifo_empty   = (countQ == '0);
  assign fifo_full    = (countQ == DepthC);
  assign almost_full  = (countQ >= AfC);
  assign almost_empty = (countQ <= AeC);

  // A full FIFO still takes a write when a read frees a slot in the same cycle.
  assign rdAccept = re && !fifo_empty;
  assign wrAccept = we && (!fifo_full || rdAccept);

  always_comb begin
    wrPtrD     = wrPtrQ;
    rdPtrD     = rdPtrQ;
    countD     = countQ;
    dataOutD   = dataOutQ;
    dataValidD = rdAccept;
    overflowD  = we && !wrAccept;
    underflowD = re && !rdAccept;
    memWe      = wrAccept;

    if (wrAccept) begin
      wrPtrD = (wrPtrQ == LastPtrC) ? '0 : wrPtrQ + 1'b1;
    end
    if (rdAccept) begin
      rdPtrD   = (rdPtrQ == LastPtrC) ? '0 : rdPtrQ + 1'b1;
      dataOutD = memRdData;
    end

    case ({wrAccept, rdAccept})
      2'b10:   countD = countQ + 1'b1;
      2'b01:   countD = countQ - 1'b1;
      default: countD = countQ;
    endcase

    // Flush wins over any request in the same cycle but leaves data_out alone.
    if (flush) begin
      wrPtrD     = '0;
      rdPtrD     = '0;
      countD     = '0;
      dataOutD   = dataOutQ;
      dataValidD = 1'b0;
      overflowD  = 1'b0;
      underflowD = 1'b0;
      memWe      = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtrQ     <= '0;
      rdPtrQ     <= '0;
      countQ     <= '0;
      dataOutQ   <= '0;
      dataValidQ <= 1'b0;
      overflowQ  <= 1'b0;
      underflowQ <= 1'b0;
    end else begin
      wrPtrQ     <= wrPtrD;
      rdPtrQ     <= rdPtrD;
      countQ     <= countD;
      dataOutQ   <= dataOutD;
      dataValidQ <= dataValidD;
      overflowQ  <= overflowD;
      underflowQ <= underflowD;
    end
  end

  fifo_mem #(
    .width     (width),
    .depth     (depth),
    .adr_width (adr_width)
  ) uMem (
    .clk_i    (clk),
    .wrEn_i   (memWe),
    .wrAddr_i (wrPtrQ),
    .wrData_i (data_in),
    .rdAddr_i (rdPtrQ),
    .rdData_o (memRdData)
  );

  assign data_out   = dataOutQ;
  assign data_valid = dataValidQ;
  assign count      = countQ;
  assign overflow   = overflowQ;
  assign underflow  = underflowQ;

endmodule : sync_fifo

// File: tb/tb_sync_fifo.sv
// Self-checking bench for sync_fifo: a queue scoreboard holds written words
// and is popped whenever the model expects an accepted read to surface.
module tb_sync_fifo;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic [15:0] data_in;
  logic        we;
  logic        re;
  logic [15:0] data_out;
  logic        data_valid;
  logic        fifo_full;
  logic        fifo_empty;
  logic        almost_full;
  logic        almost_empty;
  logic [3:0]  count;
  logic        overflow;
  logic        underflow;

  int          testsRun    = 0;
  int          testsFailed = 0;

  logic [15:0] sbQ[$];
  int          modelCount  = 0;
  logic [15:0] expOut      = 16'h0000;
  logic        expValid    = 1'b0;
  logic        expOv       = 1'b0;
  logic        expUn       = 1'b0;

  sync_fifo #(
    .width     (16),
    .depth     (8),
    .adr_width (3),
    .af_level  (6),
    .ae_level  (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .data_in      (data_in),
    .we           (we),
    .re           (re),
    .data_out     (data_out),
    .data_valid   (data_valid),
    .fifo_full    (fifo_full),
    .fifo_empty   (fifo_empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  // Hard stop in case the stimulus ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not finish, got running, expected done");
    $fatal(1, "[TB] timeout");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Compares every output against the model's expectation for this cycle.
  task automatic checkStatus(input string tag);
    checkOutput({tag, ":count"},    32'(count),        32'(modelCount));
    checkOutput({tag, ":full"},     32'(fifo_full),    32'(modelCount == DEPTH));
    checkOutput({tag, ":empty"},    32'(fifo_empty),   32'(modelCount == 0));
    checkOutput({tag, ":afull"},    32'(almost_full),  32'(modelCount >= 6));
    checkOutput({tag, ":aempty"},   32'(almost_empty), 32'(modelCount <= 2));
    checkOutput({tag, ":valid"},    32'(data_valid),   32'(expValid));
    checkOutput({tag, ":overflow"}, 32'(overflow),     32'(expOv));
    checkOutput({tag, ":underflow"},32'(underflow),    32'(expUn));
    checkOutput({tag, ":data"},     32'(data_out),     32'(expOut));
  endtask

  // Drives one cycle of requests, predicts its effect, then checks after the edge.
  task automatic applyStimulus(input string tag, input logic w, input logic r,
                               input logic [15:0] d, input logic fl);
    logic rdOk;
    logic wrOk;
    @(negedge clk);
    we      = w;
    re      = r;
    data_in = d;
    flush   = fl;
    rdOk = r && (modelCount > 0);
    wrOk = w && ((modelCount < DEPTH) || rdOk);
    if (fl) begin
      expValid   = 1'b0;
      expOv      = 1'b0;
      expUn      = 1'b0;
      modelCount = 0;
      sbQ.delete();
    end else begin
      expValid = rdOk;
      expOv    = w && !wrOk;
      expUn    = r && !rdOk;
      if (rdOk && sbQ.size() > 0) expOut = sbQ.pop_front();
      if (wrOk) sbQ.push_back(d);
      modelCount = modelCount + (wrOk ? 1 : 0) - (rdOk ? 1 : 0);
    end
    @(posedge clk);
    #1;
    checkStatus(tag);
  endtask

  task automatic modelReset();
    sbQ.delete();
    modelCount = 0;
    expOut     = 16'h0000;
    expValid   = 1'b0;
    expOv      = 1'b0;
    expUn      = 1'b0;
  endtask

  initial begin
    rst     = 1'b1;
    flush   = 1'b0;
    we      = 1'b0;
    re      = 1'b0;
    data_in = 16'h0000;
    repeat (3) @(posedge clk);
    #1;
    checkStatus("reset");
    @(negedge clk);
    rst = 1'b0;

    // Fill to full, then one rejected write.
    for (int i = 1; i <= 9; i++) applyStimulus("fill", 1'b1, 1'b0, 16'(i), 1'b0);
    applyStimulus("idle", 1'b0, 1'b0, 16'h0000, 1'b0);

    // Drain in order, then one rejected read; data_out must hold 0x0008.
    for (int i = 0; i < 9; i++) applyStimulus("drain", 1'b0, 1'b1, 16'h0000, 1'b0);
    applyStimulus("idle", 1'b0, 1'b0, 16'h0000, 1'b0);

    // Simultaneous write and read while empty: no bypass.
    applyStimulus("emptyWR", 1'b1, 1'b1, 16'h00AA, 1'b0);
    applyStimulus("emptyWRrd", 1'b0, 1'b1, 16'h0000, 1'b0);
    applyStimulus("idle", 1'b0, 1'b0, 16'h0000, 1'b0);

    // Simultaneous write and read while full.
    for (int i = 0; i < 8; i++) applyStimulus("fill2", 1'b1, 1'b0, 16'h0100 + 16'(i), 1'b0);
    applyStimulus("fullWR", 1'b1, 1'b1, 16'h0BEE, 1'b0);
    for (int i = 0; i < 8; i++) applyStimulus("drain2", 1'b0, 1'b1, 16'h0000, 1'b0);
    applyStimulus("idle", 1'b0, 1'b0, 16'h0000, 1'b0);

    // Five in, five out, four times so the pointers wrap repeatedly.
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 5; i++) applyStimulus("wrap_w", 1'b1, 1'b0, 16'h2000 + 16'(k * 5 + i), 1'b0);
      for (int i = 0; i < 5; i++) applyStimulus("wrap_r", 1'b0, 1'b1, 16'h0000, 1'b0);
    end

    // Random traffic with occasional flushes.
    for (int i = 0; i < 120; i++) begin
      applyStimulus("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    16'($urandom), 1'($urandom_range(0, 24) == 0));
    end
    for (int i = 0; i < DEPTH + 1; i++) applyStimulus("randDrain", 1'b0, 1'b1, 16'h0000, 1'b0);

    // Asynchronous reset mid-cycle with five entries stored.
    for (int i = 0; i < 5; i++) applyStimulus("preRst", 1'b1, 1'b0, 16'h3000 + 16'(i), 1'b0);
    @(negedge clk);
    we = 1'b0;
    re = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    modelReset();
    checkStatus("asyncRst");
    @(negedge clk);
    rst = 1'b0;
    applyStimulus("postRst_w", 1'b1, 1'b0, 16'h1234, 1'b0);
    applyStimulus("postRst_r", 1'b0, 1'b1, 16'h0000, 1'b0);
    applyStimulus("idle", 1'b0, 1'b0, 16'h0000, 1'b0);

    // Flush with three entries; requests in the flush cycle are ignored.
    for (int i = 0; i < 3; i++) applyStimulus("preFlush", 1'b1, 1'b0, 16'h4000 + 16'(i), 1'b0);
    applyStimulus("flush", 1'b1, 1'b1, 16'h5555, 1'b1);
    applyStimulus("postFlush_r", 1'b0, 1'b1, 16'h0000, 1'b0);
    applyStimulus("postFlush_w", 1'b1, 1'b0, 16'h6789, 1'b0);
    applyStimulus("postFlush_rd", 1'b0, 1'b1, 16'h0000, 1'b0);
    applyStimulus("idle", 1'b0, 1'b0, 16'h0000, 1'b0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule : tb_sync_fifo
